result_writer: RTL and testbench
================================

# result_writer

Write-back counterpart to the pricing-data reader. Accepts finished result packets from BSMODS compute modules, arbitrates among them with fixed lowest-index priority, and unpacks each packet into 32-bit words on memory write port B. Word addresses increment sequentially. After NUMRECS records, it signals batch completion to the host side and holds until the host clears it.

## Interface
- BSMODS, 1: number of compute modules feeding results.
- RESWORDS, 2: 32-bit words per result packet. RESSIZE = 32*RESWORDS.
- NUMRECS, 8: records per batch.
- BASEADDR, 32'h0: byte address of the first written word.
- clock  input  1  single clock for the whole block.
- reset  input  1  asynchronous, active-high.
- resValid  input  BSMODS  module i holds a result ready. It stays high until resAck[i].
- resData  input  BSMODS*RESSIZE  flat result buses. Module i occupies bits [i*RESSIZE +: RESSIZE]. Word 0 is the LSBs.
- resAck  output  BSMODS  one-cycle grant; packet is captured this cycle.
- addrB  output  32  byte address of the current write.
- dataB  output  32  write data.
- weB  output  1  write enable.
- batchDone  output  1  level; the batch is fully written.
- batchClear  input  1  host acknowledges batchDone and starts a new batch.

## Operation
- States: IDLE, WRITE, CKSUM (macro only), DONE. Reset enters IDLE.
- IDLE:
  - If any resValid bit is set, select the lowest index i with resValid[i]=1.
  - Assert resAck[i] combinationally, load resData slice i into the shift register, clear the word-in-record counter, and go to WRITE.
- WRITE:
  - weB=1; dataB = shift register [31:0].
  - addrB = BASEADDR + {wordCount, 2'b00}. wordCount counts words written in the batch.
  - Each cycle: shift right by 32, increment wordCount and the word-in-record counter.
  - On the last word of a record, increment recCount.
  - Exit after the last word of a record: go to IDLE if recCount+1 < NUMRECS. Otherwise go to CKSUM (macro) or DONE.
- DONE:
  - batchDone=1; no acks are issued, so requests are held off.
  - On batchClear: clear wordCount, recCount and the checksum, then go to IDLE.
- Counter widths:
  - wordCount: $clog2(NUMRECS*RESWORDS+1) bits, zero-extended before the shift.
  - recCount: $clog2(NUMRECS+1) bits.
  - Neither counter wraps within a batch; both are cleared only by reset or batchClear.

## Timing
- Reset values: resAck=0, weB=0, dataB=0, addrB=BASEADDR, batchDone=0. All counters and the shift register are 0.
- weB, dataB, addrB and batchDone derive only from registered state and counters (Moore). resAck is the only combinational output, a function of IDLE and resValid.
- Per record: 1 ack cycle followed by RESWORDS write cycles. Peak throughput is one record per RESWORDS+1 cycles.
- The first write appears the cycle after resAck.
- Simultaneous resValid bits: only the lowest index is acked; the others are served in later IDLE visits.
- resValid changes during WRITE/CKSUM/DONE are ignored. batchClear outside DONE is ignored.
- Reset mid-record aborts it: the partial record is not re-sent, and write addressing restarts at BASEADDR.
- batchDone rises one cycle after the final write (data or checksum). It falls the cycle after batchClear is sampled.

## Configuration
- RESULT_WRITER_CHECKSUM_EN defined:
  - A 32-bit XOR accumulator folds in every dataB written while in WRITE.
  - After the final record, CKSUM writes the accumulator for one cycle at BASEADDR + 4*NUMRECS*RESWORDS, then the block goes to DONE.
- Undefined: no accumulator and no CKSUM state; WRITE goes directly to DONE.

## Structure
- Shared package holds:
  - the state enum (logic [1:0]);
  - default BSMODS, RESWORDS, NUMRECS;
  - the word width constant (32).
- Counters reuse the existing VarCount module (WIDTH, DEFAULT_VAL, INC_AMT parameters; inc/clear inputs), one instance each for wordCount and recCount.
- Arbitration and shift register stay inline; no other sub-module.

## Test plan
- Reset then idle, no resValid → all outputs hold their reset values; weB stays 0 for 20 cycles.
- BSMODS=1, RESWORDS=2, one packet 64'h0000_0002_0000_0001:
  - resAck pulses one cycle.
  - Next two cycles write 1 @ 0x0 and 2 @ 0x4.
  - Then IDLE.
- BSMODS=2, both resValid high with distinct packets → module 0 is acked first and written at 0x0/0x4. Module 1 is acked on the following IDLE cycle and written at 0x8/0xC.
- NUMRECS=8 back-to-back single-module packets (NUMRECS*RESWORDS=16 words) → 16 writes at 0x0..0x3C.
  - Without macro: batchDone rises the next cycle.
  - With macro: checksum (XOR of all 16 words) is written at 0x40, then batchDone rises.
  - In DONE: resValid is not acked; batchClear returns to IDLE and the next record writes at 0x0.
- Assert reset midway through a record's second word → outputs return to reset values immediately. The next packet writes at BASEADDR and the batch count restarts.

Source files
------------

// File: rtl/result_writer_pkg.sv
// Shared types and defaults for the result write-back path.
package result_writer_pkg;

  localparam int WORD_W       = 32;
  localparam int DEF_BSMODS   = 1;
  localparam int DEF_RESWORDS = 2;
  localparam int DEF_NUMRECS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CKSUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/result_writer_varcount.sv
// VarCount: loadable-default up-counter with synchronous clear (clear wins over inc).
module VarCount #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter logic [WIDTH-1:0] INC_AMT     = WIDTH'(1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= DEFAULT_VAL;
    end else if (i_clear) begin
      r_count <= DEFAULT_VAL;
    end else if (i_inc) begin
      r_count <= r_count + INC_AMT;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/result_writer.sv
// Arbitrates result packets (lowest index wins) and streams them as 32-bit writes; one ack cycle then RESWORDS writes.
// Requests wait in IDLE only; DONE holds off acks until batchClear. RESULT_WRITER_CHECKSUM_EN appends an XOR checksum word.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int          BSMODS   = DEF_BSMODS,
  parameter int          RESWORDS = DEF_RESWORDS,
  parameter int          NUMRECS  = DEF_NUMRECS,
  parameter logic [31:0] BASEADDR = 32'h0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [BSMODS-1:0]                   resValid,
  input  logic [BSMODS*RESWORDS*WORD_W-1:0]   resData,
  output logic [BSMODS-1:0]                   resAck,
  output logic [31:0]                         addrB,
  output logic [31:0]                         dataB,
  output logic                                weB,
  output logic                                batchDone,
  input  logic                                batchClear
);

  localparam int RESSIZE = WORD_W * RESWORDS;
  localparam int WC_W    = $clog2(NUMRECS * RESWORDS + 1);
  localparam int RC_W    = $clog2(NUMRECS + 1);
  localparam int WIR_W   = $clog2(RESWORDS + 1);
  localparam int SEL_W   = (BSMODS > 1) ? $clog2(BSMODS) : 1;

`ifdef RESULT_WRITER_CHECKSUM_EN
  localparam state_t ST_AFTER = ST_CKSUM;
`else
  localparam state_t ST_AFTER = ST_DONE;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [RESSIZE-1:0] r_shift;
  logic [WIR_W-1:0]   r_wir;
  logic [WC_W-1:0]    w_word_cnt;
  logic [RC_W-1:0]    w_rec_cnt;
  logic               w_any;
  logic [SEL_W-1:0]   w_sel;
  logic               w_grant;
  logic               w_last_word;
  logic               w_batch_end;
  logic               w_clear;
  logic               w_word_inc;
  logic               w_rec_inc;

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = BSMODS - 1; i >= 0; i--) begin
      if (resValid[i]) begin
        w_any = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
  end

  // Gated by reset so no grant is shown while capture is impossible.
  assign w_grant = (r_state == ST_IDLE) && w_any && !reset;

  always_comb begin
    resAck = '0;
    for (int i = 0; i < BSMODS; i++) begin
      resAck[i] = w_grant && (w_sel == SEL_W'(i));
    end
  end

  assign w_last_word = (r_wir == WIR_W'(RESWORDS - 1));
  assign w_batch_end = (int'(w_rec_cnt) + 1) >= NUMRECS;
  assign w_clear     = (r_state == ST_DONE) && batchClear;
  assign w_word_inc  = (r_state == ST_WRITE);
  assign w_rec_inc   = (r_state == ST_WRITE) && w_last_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_last_word) w_next = w_batch_end ? ST_AFTER : ST_IDLE;
      end
`ifdef RESULT_WRITER_CHECKSUM_EN
      ST_CKSUM: begin
        w_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (batchClear) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_wir   <= '0;
    end else if (w_grant) begin
      r_shift <= resData[int'(w_sel)*RESSIZE +: RESSIZE];
      r_wir   <= '0;
    end else if (r_state == ST_WRITE) begin
      r_shift <= r_shift >> WORD_W;
      r_wir   <= r_wir + WIR_W'(1);
    end
  end

  VarCount #(
    .WIDTH      (WC_W),
    .DEFAULT_VAL({WC_W{1'b0}}),
    .INC_AMT    (WC_W'(1))
  ) u_word_cnt (
    .i_clock(clock),
    .i_reset(reset),
    .i_inc  (w_word_inc),
    .i_clear(w_clear),
    .o_count(w_word_cnt)
  );

  VarCount #(
    .WIDTH      (RC_W),
    .DEFAULT_VAL({RC_W{1'b0}}),
    .INC_AMT    (RC_W'(1))
  ) u_rec_cnt (
    .i_clock(clock),
    .i_reset(reset),
    .i_inc  (w_rec_inc),
    .i_clear(w_clear),
    .o_count(w_rec_cnt)
  );

`ifdef RESULT_WRITER_CHECKSUM_EN
  logic [31:0] r_cksum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cksum <= '0;
    end else if (w_clear) begin
      r_cksum <= '0;
    end else if (r_state == ST_WRITE) begin
      r_cksum <= r_cksum ^ r_shift[31:0];
    end
  end
`endif

  // After the last data word the word counter already points at the checksum slot.
  assign addrB     = BASEADDR + 32'({w_word_cnt, 2'b00});
  assign batchDone = (r_state == ST_DONE);

  always_comb begin
    weB   = 1'b0;
    dataB = '0;
    if (r_state == ST_WRITE) begin
      weB   = 1'b1;
      dataB = r_shift[31:0];
    end
`ifdef RESULT_WRITER_CHECKSUM_EN
    if (r_state == ST_CKSUM) begin
      weB   = 1'b1;
      dataB = r_cksum;
    end
`endif
  end

endmodule

// File: tb/tb_result_writer.sv
// Randomized bench for result_writer against a queue-based model of the expected write stream.
module tb_result_writer;

  localparam int          BSM = 2;
  localparam int          RW  = 2;
  localparam int          NR  = 8;
  localparam logic [31:0] BA  = 32'h0;
  localparam int          RS  = 32 * RW;
`ifdef RESULT_WRITER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [BSM-1:0]    resValid = '0;
  logic [BSM*RS-1:0] resData = '0;
  logic [BSM-1:0]    resAck;
  logic [31:0]       addrB;
  logic [31:0]       dataB;
  logic              weB;
  logic              batchDone;
  logic              batchClear = 1'b0;

  result_writer #(
    .BSMODS  (BSM),
    .RESWORDS(RW),
    .NUMRECS (NR),
    .BASEADDR(BA)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .resValid  (resValid),
    .resData   (resData),
    .resAck    (resAck),
    .addrB     (addrB),
    .dataB     (dataB),
    .weB       (weB),
    .batchDone (batchDone),
    .batchClear(batchClear)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    bit          fin;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_words;
  int          m_recs;
  bit          m_done;
  logic [31:0] m_cksum;
  int          p_valid = 0;
  int          p_clear = 0;
  logic [BSM-1:0] src_en = '0;
  logic [BSM-1:0] ack_seen = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_words = 0;
    m_recs  = 0;
    m_done  = 1'b0;
    m_cksum = '0;
  endtask

  task automatic new_packet(input int i);
    resValid[i] = 1'b1;
    for (int k = 0; k < RW; k++) resData[i*RS + k*32 +: 32] = $urandom();
  endtask

  // One clock: compare at the falling edge, advance the model, then drive after the rising edge.
  task automatic do_cycle();
    logic [BSM-1:0] e_ack;
    int             e_idx;
    wr_t            w;
    logic [RS-1:0]  pkt;
    @(negedge clock);
    e_ack = '0;
    e_idx = -1;
    if (!m_done && exp_q.size() == 0) begin
      for (int i = BSM - 1; i >= 0; i--) begin
        if (resValid[i]) begin
          e_ack = BSM'(1) << i;
          e_idx = i;
        end
      end
    end
    check_eq("resAck", 64'(resAck), 64'(e_ack));
    check_eq("batchDone", 64'(batchDone), 64'(m_done));
    if (exp_q.size() > 0) begin
      w = exp_q[0];
      check_eq("weB", 64'(weB), 64'd1);
      check_eq("addrB", 64'(addrB), 64'(w.a));
      check_eq("dataB", 64'(dataB), 64'(w.d));
    end else begin
      check_eq("weB_idle", 64'(weB), 64'd0);
    end
    ack_seen = resAck;

    if (m_done) begin
      if (batchClear) begin
        m_done  = 1'b0;
        m_words = 0;
        m_recs  = 0;
        m_cksum = '0;
      end
    end else if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      if (w.fin) m_done = 1'b1;
    end else if (e_idx >= 0) begin
      pkt = resData[e_idx*RS +: RS];
      m_recs++;
      for (int k = 0; k < RW; k++) begin
        w.a   = BA + 32'(4 * m_words);
        w.d   = pkt[k*32 +: 32];
        w.fin = (m_recs == NR) && (k == RW - 1) && !CK;
        m_cksum ^= w.d;
        m_words++;
        exp_q.push_back(w);
      end
      if (m_recs == NR && CK) begin
        w.a   = BA + 32'(4 * NR * RW);
        w.d   = m_cksum;
        w.fin = 1'b1;
        exp_q.push_back(w);
      end
    end

    @(posedge clock);
    #1;
    for (int i = 0; i < BSM; i++) begin
      if (ack_seen[i]) resValid[i] = 1'b0;
      if (!resValid[i] && src_en[i] && ($urandom_range(0, 99) < p_valid)) new_packet(i);
    end
    batchClear = ($urandom_range(0, 99) < p_clear);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) do_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_resAck"}, 64'(resAck), 64'd0);
    check_eq({tag, "_weB"}, 64'(weB), 64'd0);
    check_eq({tag, "_dataB"}, 64'(dataB), 64'd0);
    check_eq({tag, "_addrB"}, 64'(addrB), 64'(BA));
    check_eq({tag, "_batchDone"}, 64'(batchDone), 64'd0);
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_outputs("rst");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Idle with no requests.
    run(20);

    // Single known packet: 1 @ 0x0, 2 @ 0x4.
    resValid[0] = 1'b1;
    resData[0 +: RS] = 64'h0000_0002_0000_0001;
    run(4);

    // Both modules request together; module 0 must win first.
    new_packet(0);
    new_packet(1);
    run(8);

    // Random contention with random clears.
    src_en  = 2'b11;
    p_valid = 40;
    p_clear = 20;
    run(60);

    // Back-to-back module 0 until the batch closes, then hold in DONE.
    src_en  = 2'b01;
    p_valid = 100;
    p_clear = 0;
    run(35);
    p_clear = 100;
    run(1);
    p_clear = 0;
    run(30);
    check_eq("full_batch_done", 64'(batchDone), 64'd1);
    p_clear = 100;
    run(1);
    p_clear = 0;
    src_en  = '0;
    run(6);

    // One complete record, then reset during the second word of the next.
    new_packet(0);
    run(3);
    new_packet(0);
    run(2);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    ack_seen = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    new_packet(0);
    run(4);

    // Long random run across several batches.
    src_en  = 2'b11;
    p_valid = 50;
    p_clear = 30;
    run(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
